// File: rtl/calc1_port_engine.sv
// Responder end of one calc1 request port: takes a two-cycle command, evaluates it
// and launches a one-cycle registered response a fixed number of cycles later.
module calc1_port_engine #(
   parameter int RESP_DELAY = 3   // operand-2 capture edge to response launch edge, 1..15
) (
   input  logic        c_clk,
   input  logic        reset,
   input  logic [0:3]  req_cmd_in,
   input  logic [0:31] req_data_in,
   output logic [0:1]  out_resp,
   output logic [0:31] out_data,
   output logic        busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] OPND2 = 2'd1;
   localparam logic [1:0] EXEC  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;

   localparam logic [3:0] CNT_LOAD = 4'(RESP_DELAY - 1);

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [3:0]  cmd;
   logic [31:0] op1;
   logic [31:0] op2;

   logic [32:0] sum;
   logic [1:0]  resp_calc;
   logic [31:0] data_calc;

   // NOTE: every output of always_comb gets a default first so no path can infer a latch.
   always_comb begin
      sum       = {1'b0, op1} + {1'b0, op2};
      resp_calc = RESP_ERR;
      data_calc = '0;
      case (cmd)
         CMD_ADD: if (!sum[32]) begin
            resp_calc = RESP_OK;
            data_calc = sum[31:0];
         end
         CMD_SUB: if (op2 <= op1) begin
            resp_calc = RESP_OK;
            data_calc = op1 - op2;
         end
         CMD_SHL: begin
            resp_calc = RESP_OK;
            data_calc = op1 << op2[4:0];
         end
         CMD_SHR: begin
            resp_calc = RESP_OK;
            data_calc = op1 >> op2[4:0];
         end
         default: ;
      endcase
   end

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         cmd      <= '0;
         op1      <= '0;
         op2      <= '0;
         out_resp <= RESP_NONE;
         out_data <= '0;
         busy     <= 1'b0;
      end else begin
         // Response is a single-cycle pulse; only RESP overrides these defaults.
         out_resp <= RESP_NONE;
         out_data <= '0;
         case (state)
            IDLE: if (req_cmd_in != 4'd0) begin
               cmd   <= req_cmd_in;
               op1   <= req_data_in;
               busy  <= 1'b1;
               state <= OPND2;
            end
            OPND2: begin
               op2   <= req_data_in;
               cnt   <= CNT_LOAD;
               state <= (RESP_DELAY == 1) ? RESP : EXEC;
            end
            EXEC: begin
               // Leave EXEC on the edge that takes the counter to zero.
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= RESP;
            end
            RESP: begin
               out_resp <= resp_calc;
               out_data <= data_calc;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calc1_port_engine.sv
// Randomised scoreboard bench for calc1_port_engine: the driver predicts each response
// from plain arithmetic and a cycle-level acceptance rule; a monitor checks every cycle.
module tb_calc1_port_engine;

   localparam int D = 3;

   logic        c_clk = 1'b0;
   logic        reset;
   logic [0:3]  req_cmd_in;
   logic [0:31] req_data_in;
   logic [0:1]  out_resp;
   logic [0:31] out_data;
   logic        busy;

   calc1_port_engine #(.RESP_DELAY(D)) dut (
      .c_clk       (c_clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .out_resp    (out_resp),
      .out_data    (out_data),
      .busy        (busy)
   );

   always #5 c_clk = ~c_clk;

   // Edge counter: after rising edge k has been processed, cyc == k.
   int cyc = 0;
   always @(posedge c_clk) cyc <= cyc + 1;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
      int          at;
   } exp_t;

   exp_t q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // Reference-model bookkeeping
   int          next_free = 0;
   int          busy_lo   = 0;
   int          busy_hi   = 0;
   bit          pend      = 1'b0;
   int          op2_at    = 0;
   logic [3:0]  pcmd      = '0;
   logic [31:0] pa        = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, act, req, cyc);
      end
   endtask

   function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      longint unsigned s;
      e.resp = 2'd2;
      e.data = 32'd0;
      e.at   = 0;
      case (c)
         4'd1: begin
            s = 64'(a) + 64'(b);
            if (s <= 64'hFFFF_FFFF) begin
               e.resp = 2'd1;
               e.data = a + b;
            end
         end
         4'd2: if (b <= a) begin
            e.resp = 2'd1;
            e.data = a - b;
         end
         4'd5: begin
            e.resp = 2'd1;
            e.data = a << (b % 32);
         end
         4'd6: begin
            e.resp = 2'd1;
            e.data = a >> (b % 32);
         end
         default: ;
      endcase
      return e;
   endfunction

   // Called at a falling edge; drives inputs for the next rising edge and
   // predicts what that edge does.
   task automatic step(input logic [3:0] c_in, input logic [31:0] d_in);
      int   c;
      exp_t e;
      c = cyc + 1;
      if (pend && c == op2_at) begin
         e    = model(pcmd, pa, d_in);
         e.at = c + D;
         q.push_back(e);
         pend = 1'b0;
      end else if (c_in != 4'd0 && c >= next_free) begin
         pend      = 1'b1;
         pcmd      = c_in;
         pa        = d_in;
         op2_at    = c + 1;
         next_free = c + D + 2;
         busy_lo   = c;
         busy_hi   = c + 1 + D;
      end
      req_cmd_in  = c_in;
      req_data_in = d_in;
      @(negedge c_clk);
   endtask

   task automatic issue(input logic [3:0] c_in, input logic [31:0] a, input logic [31:0] b);
      while (cyc + 1 < next_free) step(4'd0, $urandom);
      step(c_in, a);
      step(4'($urandom_range(0, 15)), b);
   endtask

   task automatic idle(input int n);
      repeat (n) step(4'd0, $urandom);
   endtask

   // Monitor: every cycle, just after the rising edge
   initial begin
      exp_t e;
      forever begin
         @(posedge c_clk);
         #1;
         check("busy", 64'(busy), 64'(cyc >= busy_lo && cyc < busy_hi));
         if (q.size() > 0 && q[0].at < cyc) begin
            check("missing_resp_edge", 64'(cyc), 64'(q[0].at));
            void'(q.pop_front());
         end
         if (out_resp !== 2'd0) begin
            if (q.size() == 0) begin
               check("unexpected_resp", 64'(out_resp), 64'd0);
            end else begin
               e = q.pop_front();
               check("resp", 64'(out_resp), 64'(e.resp));
               check("data", 64'(out_data), 64'(e.data));
               check("launch_edge", 64'(cyc), 64'(e.at));
            end
         end else begin
            check("idle_data", 64'(out_data), 64'd0);
         end
      end
   end

   initial begin
      logic [3:0]  rc;
      logic [31:0] rd;
      int          r;

      reset       = 1'b1;
      req_cmd_in  = '0;
      req_data_in = '0;
      repeat (2) @(negedge c_clk);
      check("reset_resp", 64'(out_resp), 64'd0);
      check("reset_data", 64'(out_data), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      idle(2);

      // Directed cases
      issue(4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
      issue(4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
      issue(4'd2, 32'd5, 32'd7);
      issue(4'd2, 32'd7, 32'd5);
      issue(4'd5, 32'h0000_0001, 32'h0000_0021);
      issue(4'd6, 32'h8000_0000, 32'd31);
      issue(4'd3, $urandom, $urandom);
      issue(4'd1, 32'hFFFF_FFFE, 32'h0000_0001);
      issue(4'd2, 32'd9, 32'd9);

      // Commands re-presented while busy and at the launch edge are ignored
      while (cyc + 1 < next_free) step(4'd0, 32'd0);
      step(4'd1, 32'd1);          // E0
      step(4'd0, 32'd1);          // E1
      step(4'd1, 32'd40);         // E2 ignored
      step(4'd0, 32'd0);          // E3
      step(4'd1, 32'd50);         // E4 ignored (launch edge)
      step(4'd2, 32'd100);        // E5 accepted
      step(4'd0, 32'd30);         // E6, response at E9
      idle(D + 3);

      // Reset in the middle of an operation
      issue(4'd1, 32'd1, 32'd1);  // ends after E1
      step(4'd0, 32'd0);          // E2
      reset = 1'b1;
      #1;
      check("midreset_resp", 64'(out_resp), 64'd0);
      check("midreset_data", 64'(out_data), 64'd0);
      check("midreset_busy", 64'(busy), 64'd0);
      q.delete();
      pend      = 1'b0;
      next_free = 0;
      busy_hi   = 0;
      repeat (2) @(negedge c_clk);
      reset = 1'b0;
      idle(10);
      issue(4'd2, 32'd100, 32'd40);
      idle(D + 3);

      // Random traffic, including commands offered while busy
      repeat (400) begin
         r = $urandom_range(0, 9);
         case (r)
            4:       rc = 4'd1;
            5:       rc = 4'd2;
            6:       rc = 4'd5;
            7:       rc = 4'd6;
            8:       rc = 4'($urandom_range(1, 15));
            9:       rc = 4'($urandom_range(3, 4));
            default: rc = 4'd0;
         endcase
         case ($urandom_range(0, 7))
            0:       rd = 32'd0;
            1:       rd = 32'hFFFF_FFFF;
            2:       rd = 32'h8000_0000;
            3:       rd = 32'($urandom_range(0, 40));
            default: rd = $urandom;
         endcase
         step(rc, rd);
      end

      idle(D + 4);
      check("scoreboard_empty", 64'(q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
